optic_tx: RTL and testbench

Serial optical-link transmitter. Each frame carries one byte as serial NRZ at 50 Mb/s on a single fiber line, clocked at 250 MHz (5 clocks per bit). A frame is an 8-bit header 8'h01, the data byte, its bitwise complement as a check byte, and a high tail. The block is the far-end partner of the link receiver: its line output drives the optical PHY, and at the other end the receiver recovers the byte, checks it, and raises its verify and comm errors.

---
 rtl/optic_pkg.sv | 17 +
 rtl/optic_tx_if.sv | 20 ++
 rtl/optic_tx_bit_timer.sv | 60 ++++++
 rtl/optic_tx.sv | 131 +++++++++++++
 tb/tb_optic_tx.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/optic_pkg.sv
// Shared constants and one-hot state encodings for the optical link.
// The receiver uses the same state codes.
package optic_pkg;

    localparam logic [7:0] HEADER_BYTE = 8'h01;
    localparam int         BIT_CLKS    = 5;
    localparam int         BIT6_CNT    = 31;

    typedef enum logic [4:0] {
        ST_IDLE   = 5'h01,
        ST_HEADER = 5'h02,
        ST_DATA   = 5'h04,
        ST_VERIFY = 5'h08,
        ST_TAIL   = 5'h10
    } state_e;

endpackage

// File: rtl/optic_tx_if.sv
// Byte-level valid/ready handshake into the optical transmitter.
interface optic_tx_if;

    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );

endinterface

// File: rtl/optic_tx_bit_timer.sv
// Clock-per-bit and bit-per-field counters for the serialiser.
module optic_tx_bit_timer #(
    parameter int BIT_CLKS  = 5,
    parameter int TAIL_BITS = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic tail,
    output logic bit_tick,
    output logic last_bit,
    output logic pre_end
);

    localparam int CW = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
    localparam int NB = (TAIL_BITS > 8) ? TAIL_BITS : 8;
    localparam int BW = $clog2(NB);

    localparam logic [CW-1:0] CLK_MAX  = CW'(BIT_CLKS - 1);
    localparam logic [CW-1:0] CLK_PRE  = CW'(BIT_CLKS - 2);
    localparam logic [BW-1:0] DATA_MAX = BW'(7);
    localparam logic [BW-1:0] TAIL_MAX = BW'(TAIL_BITS - 1);

    logic [CW-1:0] bit_clk_cnt_q, bit_clk_cnt_d;
    logic [BW-1:0] bit_cnt_q, bit_cnt_d;
    logic [BW-1:0] bit_max;
    logic          at_max;

    assign bit_max  = tail ? TAIL_MAX : DATA_MAX;
    assign at_max   = (bit_cnt_q == bit_max);
    assign bit_tick = (bit_clk_cnt_q == CLK_MAX);
    assign last_bit = bit_tick && at_max;
    // One clock before the field ends; lets the top register frame_done.
    assign pre_end  = at_max && (bit_clk_cnt_q == CLK_PRE);

    always_comb begin
        bit_clk_cnt_d = bit_clk_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        if (clr) begin
            bit_clk_cnt_d = '0;
            bit_cnt_d     = '0;
        end else if (bit_tick) begin
            bit_clk_cnt_d = '0;
            bit_cnt_d     = at_max ? '0 : bit_cnt_q + 1'b1;
        end else begin
            bit_clk_cnt_d = bit_clk_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_clk_cnt_q <= '0;
            bit_cnt_q     <= '0;
        end else begin
            bit_clk_cnt_q <= bit_clk_cnt_d;
            bit_cnt_q     <= bit_cnt_d;
        end
    end

endmodule

// File: rtl/optic_tx.sv
// Optical-link transmitter: header 8'h01, data byte, complement, high tail.
// Serial NRZ, MSB first, BIT_CLKS clocks per bit, registered line output.
module optic_tx
    import optic_pkg::*;
#(
    parameter int BIT_CLKS    = optic_pkg::BIT_CLKS,
    parameter int TAIL_BITS   = 8,
    parameter bit AUTO_REPEAT = 1'b1
) (
    input  logic       clk_tx,
    input  logic       reset,
    optic_tx_if.slave  tx,
    output logic       phy_txd,
    output logic       tx_busy,
    output logic       frame_done
);

    state_e     state_q, state_d;
    logic [7:0] data_q, data_d;
    logic [7:0] sr_q, sr_d;
    logic       have_q, have_d;
    logic       phy_txd_q, phy_txd_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       ready_q, ready_d;

    logic       clr;
    logic       bit_tick;
    logic       last_bit;
    logic       pre_end;

    optic_tx_bit_timer #(
        .BIT_CLKS  (BIT_CLKS),
        .TAIL_BITS (TAIL_BITS)
    ) u_timer (
        .clk      (clk_tx),
        .rst      (reset),
        .clr      (clr),
        .tail     (state_q == ST_TAIL),
        .bit_tick (bit_tick),
        .last_bit (last_bit),
        .pre_end  (pre_end)
    );

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        have_d  = have_q;
        done_d  = 1'b0;
        sr_d    = bit_tick ? {sr_q[6:0], 1'b1} : sr_q;

        unique case (state_q)
            ST_IDLE: begin
                if (tx.tx_valid && ready_q) begin
                    data_d  = tx.tx_data;
                    have_d  = 1'b1;
                    state_d = ST_HEADER;
                    sr_d    = HEADER_BYTE;
                end else if (AUTO_REPEAT && have_q) begin
                    state_d = ST_HEADER;
                    sr_d    = HEADER_BYTE;
                end
            end
            ST_HEADER: begin
                if (last_bit) begin
                    state_d = ST_DATA;
                    sr_d    = data_q;
                end
            end
            ST_DATA: begin
                if (last_bit) begin
                    state_d = ST_VERIFY;
                    sr_d    = ~data_q;
                end
            end
            ST_VERIFY: begin
                if (last_bit) begin
                    state_d = ST_TAIL;
                end
            end
            ST_TAIL: begin
                done_d = pre_end;
                if (last_bit) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are precomputed from the next state so they line up with it.
        phy_txd_d = 1'b1;
        if (state_d == ST_HEADER || state_d == ST_DATA
            || state_d == ST_VERIFY) begin
            phy_txd_d = sr_d[7];
        end
        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_IDLE);
    end

    assign clr = (state_d != state_q) || (state_q == ST_IDLE);

    always_ff @(posedge clk_tx or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            data_q    <= 8'h00;
            sr_q      <= 8'h00;
            have_q    <= 1'b0;
            phy_txd_q <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            sr_q      <= sr_d;
            have_q    <= have_d;
            phy_txd_q <= phy_txd_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
        end
    end

    assign phy_txd     = phy_txd_q;
    assign tx_busy     = busy_q;
    assign frame_done  = done_q;
    assign tx.tx_ready = ready_q;

endmodule

// File: tb/tb_optic_tx.sv
// Directed and randomized checks of optic_tx against a frame-level model.
module tb_optic_tx;

    localparam int BC    = 5;
    localparam int FRAME = (24 + 8) * BC;

    logic clk = 1'b0;
    logic rst;
    bit   sel;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    optic_tx_if na_if ();
    optic_tx_if ar_if ();

    logic na_txd, na_busy, na_done;
    logic ar_txd, ar_busy, ar_done;

    optic_tx #(
        .AUTO_REPEAT (1'b0)
    ) u_na (
        .clk_tx     (clk),
        .reset      (rst),
        .tx         (na_if),
        .phy_txd    (na_txd),
        .tx_busy    (na_busy),
        .frame_done (na_done)
    );

    optic_tx #(
        .AUTO_REPEAT (1'b1)
    ) u_ar (
        .clk_tx     (clk),
        .reset      (rst),
        .tx         (ar_if),
        .phy_txd    (ar_txd),
        .tx_busy    (ar_busy),
        .frame_done (ar_done)
    );

    function automatic logic f_txd();
        return sel ? ar_txd : na_txd;
    endfunction

    function automatic logic f_busy();
        return sel ? ar_busy : na_busy;
    endfunction

    function automatic logic f_done();
        return sel ? ar_done : na_done;
    endfunction

    function automatic logic f_rdy();
        return sel ? ar_if.tx_ready : na_if.tx_ready;
    endfunction

    // Line level on clock k (0-based) of a frame carrying byte b.
    function automatic logic exp_line(input logic [7:0] b, input int k);
        int         i;
        logic [7:0] f;
        i = k / BC;
        if (i >= 24) return 1'b1;
        if (i < 8) f = 8'h01;
        else if (i < 16) f = b;
        else f = ~b;
        return f[7 - (i % 8)];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input bit s, input logic v, input logic [7:0] d);
        if (s) begin
            ar_if.tx_valid = v;
            ar_if.tx_data  = d;
        end else begin
            na_if.tx_valid = v;
            na_if.tx_data  = d;
        end
    endtask

    // Present a byte and wait (bounded) until the block is ready to take it.
    task automatic send(input bit s, input logic [7:0] b,
                        input int exp_wait, input string tag);
        int w;
        w   = 0;
        sel = s;
        drive(s, 1'b1, b);
        while (!f_rdy() && w < 400) begin
            @(negedge clk);
            w++;
        end
        chk({tag, "_wait"}, w, exp_wait);
    endtask

    // Check len clocks of a frame of byte b; optionally present nxt at nxt_at.
    task automatic frame(input logic [7:0] b, input string tag, input int len,
                         input int nxt_at, input logic [7:0] nxt);
        int line_err, busy_err, rdy_err, done_cnt, done_k;
        line_err = 0; busy_err = 0; rdy_err = 0; done_cnt = 0; done_k = -1;
        for (int k = 0; k < len; k++) begin
            @(negedge clk);
            if (k == 0) drive(sel, 1'b0, 8'h00);
            if (k == nxt_at) drive(sel, 1'b1, nxt);
            if (f_txd() !== exp_line(b, k)) line_err++;
            if (f_busy() !== 1'b1) busy_err++;
            if (f_rdy() !== 1'b0) rdy_err++;
            if (f_done() === 1'b1) begin
                done_cnt++;
                done_k = k;
            end
        end
        chk({tag, "_line"}, line_err, 0);
        chk({tag, "_busy"}, busy_err, 0);
        chk({tag, "_rdy"}, rdy_err, 0);
        if (len == FRAME) begin
            chk({tag, "_done_cnt"}, done_cnt, 1);
            chk({tag, "_done_pos"}, done_k, FRAME - 1);
        end else begin
            chk({tag, "_no_done"}, done_cnt, 0);
        end
    endtask

    task automatic idle(input int n, input string tag);
        int viol;
        viol = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            if (f_txd() !== 1'b1 || f_busy() !== 1'b0
                || f_done() !== 1'b0 || f_rdy() !== 1'b1) viol++;
        end
        chk(tag, viol, 0);
    endtask

    // The single IDLE clock between repeated/back-to-back frames.
    task automatic gap(input string tag);
        @(negedge clk);
        chk({tag, "_gap"}, {f_txd(), f_busy(), f_rdy(), f_done()}, 4'b1010);
    endtask

    initial begin
        logic [7:0] rb;
        logic [7:0] rn;
        rst = 1'b1;
        sel = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        drive(1'b1, 1'b0, 8'h00);
        repeat (3) @(negedge clk);

        chk("rst_na", {na_txd, na_busy, na_done, na_if.tx_ready}, 4'b1001);
        chk("rst_ar", {ar_txd, ar_busy, ar_done, ar_if.tx_ready}, 4'b1001);
        rst = 1'b0;

        sel = 1'b0;
        idle(1000, "idle_na");
        sel = 1'b1;
        idle(50, "idle_ar");

        send(1'b0, 8'hA5, 0, "a5");
        frame(8'hA5, "a5", FRAME, -1, 8'h00);
        idle(30, "a5_after");

        send(1'b0, 8'h3C, 0, "b2b0");
        frame(8'h3C, "b2b0", FRAME, FRAME - 1, 8'hFF);
        send(1'b0, 8'hFF, 1, "b2b1");
        frame(8'hFF, "b2b1", FRAME, -1, 8'h00);
        idle(10, "b2b_after");

        send(1'b0, 8'h96, 0, "hold0");
        frame(8'h96, "hold0", FRAME, 20, 8'h81);
        send(1'b0, 8'h81, 1, "hold1");
        frame(8'h81, "hold1", FRAME, -1, 8'h00);
        idle(10, "hold_after");

        rb = 8'($urandom);
        send(1'b0, rb, 0, "rnd0");
        frame(rb, "rnd0", FRAME, -1, 8'h00);

        send(1'b1, 8'h5A, 0, "ar0");
        frame(8'h5A, "ar0", FRAME, -1, 8'h00);
        gap("ar0");
        frame(8'h5A, "ar1", FRAME, 100, 8'h11);
        send(1'b1, 8'h11, 1, "ar2");
        frame(8'h11, "ar2", FRAME, -1, 8'h00);
        gap("ar2");
        frame(8'h11, "ar3", FRAME, -1, 8'h00);

        rn = 8'($urandom);
        send(1'b1, rn, 1, "arrnd");
        frame(rn, "arrnd", FRAME, -1, 8'h00);
        gap("arrnd");
        frame(rn, "arrnd_rep", FRAME, -1, 8'h00);

        send(1'b1, 8'hC3, 1, "rst_mid");
        frame(8'hC3, "rst_mid", 52, -1, 8'h00);
        chk("rst_mid_low", ar_txd, 1'b0);
        rst = 1'b1;
        #1;
        chk("rst_mid_async", {ar_txd, ar_busy, ar_done}, 3'b100);
        @(negedge clk);
        rst = 1'b0;
        idle(400, "rst_norep");

        send(1'b1, 8'h07, 0, "post07");
        frame(8'h07, "post07", FRAME, -1, 8'h00);
        gap("post07");
        frame(8'h07, "post07_rep", FRAME, -1, 8'h00);

        rst = 1'b1;
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
